// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin / fixed-priority bus arbiter.
package arb_pkg;

  typedef enum logic [0:0] {IDLE, BUSY} arb_state_t;

  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner select: rotate requests so the search starts at the
// highest-priority slot, priority-encode, then un-rotate back to a real index.
// In fixed mode the search always starts at index 0.
module arb_rr_pick import arb_pkg::*; #(
  parameter int unsigned N = 4,
  localparam int unsigned NW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [NW-1:0] last,
  input  logic          rr_mode,
  output logic [N-1:0]  win_onehot,
  output logic [NW-1:0] win_idx,
  output logic          any
);

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [NW-1:0]  start;
  logic [NW-1:0]  k;
  logic [NW:0]    pos;

  // Rotate / priority-encode / un-rotate.
  always_comb begin
    start = '0;
    if (rr_mode == ARB_MODE_RR) begin
      start = (last == NW'(N - 1)) ? '0 : last + NW'(1);
    end
    // Doubling the vector turns the rotation into a plain right shift.
    req2 = {req, req};
    rot  = N'(req2 >> start);
    any  = 1'b0;
    k    = '0;
    for (int i = 0; i < N; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        k   = NW'(i);
      end
    end
    pos = {1'b0, start} + {1'b0, k};
    if (pos >= (NW + 1)'(N)) begin
      pos = pos - (NW + 1)'(N);
    end
    win_idx    = pos[NW-1:0];
    win_onehot = '0;
    if (any) begin
      win_onehot = N'(1) << win_idx;
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-requester bus arbiter with registered grants held until the owner drops
// its request. Fixed priority or round-robin, chosen per arbitration.
// Optional feature macro: ARB_TIMEOUT_EN -- revokes a grant after HOLD_MAX
// busy cycles when another master is waiting.
module bus_arbiter_rr import arb_pkg::*; #(
  parameter int unsigned N        = 4,
  parameter int unsigned HOLD_MAX = 16,
  localparam int unsigned NW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          rr_mode,
  output logic [N-1:0]  grant,
  output logic [NW-1:0] grant_num,
  output logic          avbl,
  output logic          timeout
);

  arb_state_t    state_q;
  logic [N-1:0]  grant_q;
  logic [NW-1:0] grant_num_q;
  logic [NW-1:0] last_q;
  logic          avbl_q;

  logic [N-1:0]  win_onehot;
  logic [NW-1:0] win_idx;
  logic          win_any;
  logic          owner_req;

  arb_rr_pick #(
    .N (N)
  ) u_pick (
    .req        (req),
    .last       (last_q),
    .rr_mode    (rr_mode),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .any        (win_any)
  );

  // grant_q is one-hot, so masking with it isolates the owner's request.
  assign owner_req = |(req & grant_q);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(HOLD_MAX + 1);

  logic [CW-1:0] hold_cnt_q;
  logic          timeout_q;
  logic          others_req;
  logic          revoke;

  assign others_req = |(req & ~grant_q);
  assign revoke     = (hold_cnt_q == CW'(HOLD_MAX)) && others_req;
  assign timeout    = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Arbitration FSM with registered outputs, pointer and optional hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_num_q <= '0;
      avbl_q      <= 1'b1;
      last_q      <= NW'(N - 1);
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (win_any) begin
            state_q     <= BUSY;
            grant_q     <= win_onehot;
            grant_num_q <= win_idx;
            avbl_q      <= 1'b0;
            last_q      <= win_idx;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= CW'(1);
`endif
          end
        end
        BUSY: begin
          if (!owner_req) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_num_q <= '0;
            avbl_q      <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= '0;
          end else if (revoke) begin
            // last_q already holds the revoked owner, so it ranks last next round.
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_num_q <= '0;
            avbl_q      <= 1'b1;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b1;
          end else if (hold_cnt_q != CW'(HOLD_MAX)) begin
            hold_cnt_q  <= hold_cnt_q + CW'(1);
`endif
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign grant_num = grant_num_q;
  assign avbl      = avbl_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr with a cycle-level reference model.
module tb_bus_arbiter_rr;
  localparam int unsigned N        = 4;
  localparam int unsigned NW       = 2;
  localparam int unsigned HOLD_MAX = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic          rr_mode = 1'b0;
  logic [N-1:0]  grant;
  logic [NW-1:0] grant_num;
  logic          avbl;
  logic          timeout;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: owner index (-1 = bus free), RR pointer, hold count.
  int m_owner;
  int m_last;
  int m_hold;
  bit m_to;

  bus_arbiter_rr #(
    .N        (N),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rr_mode   (rr_mode),
    .grant     (grant),
    .grant_num (grant_num),
    .avbl      (avbl),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic void model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_hold  = 0;
    m_to    = 1'b0;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input logic m);
    if (!m) begin
      for (int i = 0; i < N; i++) if (r[i]) return i;
    end else begin
      for (int d = 1; d <= N; d++) if (r[(m_last + d) % N]) return (m_last + d) % N;
    end
    return -1;
  endfunction

  function automatic void model_edge(input logic [N-1:0] r, input logic m);
    logic [N-1:0] others;
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (r != '0) begin
        m_owner = pick(r, m);
        m_last  = m_owner;
        m_hold  = 1;
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        m_owner = -1;
      end else if (TO_EN && m_hold == HOLD_MAX && others != '0) begin
        m_owner = -1;
        m_to    = 1'b1;
      end else if (m_hold < HOLD_MAX) begin
        m_hold++;
      end
    end
  endfunction

  function automatic logic [N+NW+1:0] exp_out();
    logic [N-1:0]  g;
    logic [NW-1:0] n;
    g = '0;
    n = '0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      n = NW'(m_owner);
    end
    return {g, n, (m_owner < 0), m_to};
  endfunction

  function automatic logic [N+NW+1:0] obs();
    return {grant, grant_num, avbl, timeout};
  endfunction

  // Apply inputs mid-cycle, advance one edge, update model, settle.
  task automatic drive(input logic [N-1:0] r, input logic m);
    @(negedge clk);
    req = r;
    rr_mode = m;
    @(posedge clk);
    model_edge(r, m);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    rr_mode = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b1111;
    model_reset();
    #1;
    tests_run++;
    if ({grant, grant_num, avbl, timeout} !== {4'b0000, 2'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: got %b want %b", obs(), {4'b0000, 2'd0, 1'b1, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 1'b0);
    tests_run++;
    if (grant !== 4'b0001 || avbl !== 1'b0 || obs() !== exp_out()) begin
      tests_failed++;
      $display("FAIL reset_release_grant: got %b want grant=0001 (%b)", obs(), exp_out());
    end
  endtask

  task automatic test_fixed();
    do_reset();
    drive(4'b1010, 1'b0);
    tests_run++;
    if (grant !== 4'b0010 || grant_num !== 2'd1 || obs() !== exp_out()) begin
      tests_failed++;
      $display("FAIL fixed_grant1: got %b want %b", obs(), exp_out());
    end
    drive(4'b1000, 1'b0);
    tests_run++;
    if (grant !== 4'b0000 || avbl !== 1'b1 || obs() !== exp_out()) begin
      tests_failed++;
      $display("FAIL fixed_release: got %b want %b", obs(), exp_out());
    end
    drive(4'b1000, 1'b0);
    tests_run++;
    if (grant !== 4'b1000 || grant_num !== 2'd3 || obs() !== exp_out()) begin
      tests_failed++;
      $display("FAIL fixed_grant3: got %b want %b", obs(), exp_out());
    end
  endtask

  task automatic test_rr_rotation();
    logic [N-1:0] drop;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      drive(4'b1111, 1'b1);
      tests_run++;
      if (grant_num !== NW'(t % N) || avbl !== 1'b0 || obs() !== exp_out()) begin
        tests_failed++;
        $display("FAIL rr_seq%0d: got num=%0d obs=%b want num=%0d", t, grant_num, obs(), t % N);
      end
      for (int h = 0; h < 2; h++) begin
        drive(4'b1111, 1'b1);
        tests_run++;
        if (obs() !== exp_out()) begin
          tests_failed++;
          $display("FAIL rr_hold%0d: got %b want %b", t, obs(), exp_out());
        end
      end
      drop = 4'b1111;
      drop[t % N] = 1'b0;
      drive(drop, 1'b1);
      tests_run++;
      if (avbl !== 1'b1 || grant !== 4'b0000 || obs() !== exp_out()) begin
        tests_failed++;
        $display("FAIL rr_gap%0d: got %b want %b", t, obs(), exp_out());
      end
    end
  endtask

  task automatic test_hold_ignore();
    do_reset();
    drive(4'b0100, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(4'b0101, i[0]);
      tests_run++;
      if (grant !== 4'b0100 || obs() !== exp_out()) begin
        tests_failed++;
        $display("FAIL hold_ignore%0d: got %b want grant=0100", i, obs());
      end
    end
    drive(4'b0001, 1'b0);
    drive(4'b0001, 1'b0);
    tests_run++;
    if (grant !== 4'b0001 || grant_num !== 2'd0 || obs() !== exp_out()) begin
      tests_failed++;
      $display("FAIL hold_next_owner: got %b want %b", obs(), exp_out());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(4'b1000, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      drive(4'b1010, 1'b1);
      tests_run++;
      if (obs() !== exp_out()) begin
        tests_failed++;
        $display("FAIL timeout_model%0d: got %b want %b", i, obs(), exp_out());
      end
`ifdef ARB_TIMEOUT_EN
      if (i == 4) begin
        tests_run++;
        if (timeout !== 1'b1 || grant !== 4'b0000 || avbl !== 1'b1) begin
          tests_failed++;
          $display("FAIL timeout_revoke: got to=%b grant=%b want to=1 grant=0000", timeout, grant);
        end
      end
      if (i == 5) begin
        tests_run++;
        if (timeout !== 1'b0 || grant !== 4'b0010) begin
          tests_failed++;
          $display("FAIL timeout_regrant: got to=%b grant=%b want to=0 grant=0010", timeout, grant);
        end
      end
`else
      tests_run++;
      if (timeout !== 1'b0 || grant !== 4'b1000) begin
        tests_failed++;
        $display("FAIL no_timeout%0d: got to=%b grant=%b want to=0 grant=1000", i, timeout, grant);
      end
`endif
    end
    // Owner alone: no one waiting, so the bus is never revoked.
    do_reset();
    for (int i = 0; i < 3 * HOLD_MAX; i++) begin
      drive(4'b1000, 1'b1);
      tests_run++;
      if (grant !== 4'b1000 || timeout !== 1'b0 || obs() !== exp_out()) begin
        tests_failed++;
        $display("FAIL timeout_alone%0d: got %b want grant=1000 to=0", i, obs());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(4'b0001, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (grant !== 4'b0000 || avbl !== 1'b1 || grant_num !== 2'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got grant=%b avbl=%b want grant=0000 avbl=1", grant, avbl);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 1'b1);
    tests_run++;
    if (grant !== 4'b0001 || obs() !== exp_out()) begin
      tests_failed++;
      $display("FAIL async_reset_ptr: got %b want grant=0001", obs());
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic         m;
    do_reset();
    r = '0;
    m = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) m = ~m;
      if ($urandom_range(0, 3) == 0) begin
        r = N'($urandom);
      end else if (m_owner >= 0 && $urandom_range(0, 4) == 0) begin
        r[m_owner] = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        r = '0;
      end
      drive(r, m);
      tests_run++;
      if (obs() !== exp_out()) begin
        tests_failed++;
        $display("FAIL random_c%0d: req=%b mode=%b got %b want %b", c, r, m, obs(), exp_out());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fixed();
    test_rr_rotation();
    test_hold_ignore();
    test_timeout();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
